// File: rtl/counter_pkg.sv
// Shared constants for the bounded sequencing counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Boundary mode encodings and a helper that folds the reserved code onto wrap.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    // 2'b11 is reserved and behaves exactly like wrap.
    function automatic logic is_wrap_mode(input logic [1:0] mode);
        return (mode != MODE_SAT) && (mode != MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/counter_bounded_next.sv
// Next-count arithmetic and boundary detection for counter_bounded.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: cnt/step/updown/min_count/max_count in; nxt (raw stepped value),
// evt_up (cnt+step overshoots max), evt_dn (cnt-step undershoots min) out.
module counter_bounded_next #(
    parameter int WIDTH  = 36,
    parameter int STEP_W = 8
) (
    input  logic [WIDTH-1:0]  cnt,
    input  logic [STEP_W-1:0] step,
    input  logic              updown,
    input  logic [WIDTH-1:0]  min_count,
    input  logic [WIDTH-1:0]  max_count,
    output logic [WIDTH-1:0]  nxt,
    output logic              evt_up,
    output logic              evt_dn
);

    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] sum_up;
    logic [WIDTH:0] sum_dn;

    // One extra bit so neither carry nor borrow is lost before comparing.
    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign sum_up   = {1'b0, cnt} + step_ext;
    assign sum_dn   = {1'b0, cnt} - step_ext;

    assign evt_up = sum_up > {1'b0, max_count};
    // Top bit set means the subtraction went negative, which is below any min.
    assign evt_dn = sum_dn[WIDTH] | (sum_dn[WIDTH-1:0] < min_count);

    assign nxt = updown ? sum_up[WIDTH-1:0] : sum_dn[WIDTH-1:0];

endmodule

// File: rtl/counter_bounded.sv
// Up/down counter with programmable step, runtime bounds and wrap/saturate/one-shot mode.
// Latency: inputs sampled at edge N appear on cnt/tc/ovf/done after edge N; no comb in->out.
// Backpressure: none; ena is advisory, done freezes counting until load or rst.
//
// Ports: clk, rst (async high); ena, updown, step, min_count, max_count, mode,
// load, load_val, clr_ovf in; cnt, tc (terminal pulse), ovf (sticky wrap), done out.
module counter_bounded
    import counter_pkg::*;
#(
    parameter int               WIDTH   = 36,
    parameter int               STEP_W  = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              updown,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  min_count,
    input  logic [WIDTH-1:0]  max_count,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  cnt,
    output logic              tc,
    output logic              ovf,
    output logic              done
);

    logic [WIDTH-1:0] nxt;
    logic             evt_up;
    logic             evt_dn;
    logic             evt;
    logic             adv;

    logic [WIDTH-1:0] cnt_d;
    logic             tc_d;
    logic             ovf_d;
    logic             done_d;

    counter_bounded_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .cnt       (cnt),
        .step      (step),
        .updown    (updown),
        .min_count (min_count),
        .max_count (max_count),
        .nxt       (nxt),
        .evt_up    (evt_up),
        .evt_dn    (evt_dn)
    );

    assign evt = updown ? evt_up : evt_dn;
    // A zero step is a hold; it must not raise an event even if cnt sits outside the bounds.
    assign adv = ena && !done && (step != '0);

    always_comb begin
        cnt_d  = cnt;
        tc_d   = 1'b0;
        ovf_d  = ovf;
        done_d = done;

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        if (load) begin
            cnt_d  = load_val;
            done_d = 1'b0;
        end else if (adv) begin
            if (evt) begin
                tc_d = 1'b1;
                if (is_wrap_mode(mode)) begin
                    cnt_d = updown ? min_count : max_count;
                    ovf_d = 1'b1;   // overrides a same-cycle clr_ovf
                end else begin
                    cnt_d = updown ? max_count : min_count;
                    if (mode == MODE_ONESHOT) begin
                        done_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= RST_VAL;
            tc   <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            tc   <= tc_d;
            ovf  <= ovf_d;
            done <= done_d;
        end
    end

endmodule

// File: tb/tb_counter_bounded.sv
// Directed self-checking bench for counter_bounded.
// Latency: expectations are queued as each cycle is driven and popped one edge later.
// Backpressure: n/a.
module tb_counter_bounded;

    localparam int               W      = 36;
    localparam int               SW     = 8;
    localparam logic [W-1:0]     MAXW   = {W{1'b1}};

    logic          clk;
    logic          rst;
    logic          ena;
    logic          updown;
    logic [SW-1:0] step;
    logic [W-1:0]  min_count;
    logic [W-1:0]  max_count;
    logic [1:0]    mode;
    logic          load;
    logic [W-1:0]  load_val;
    logic          clr_ovf;
    logic [W-1:0]  cnt;
    logic          tc;
    logic          ovf;
    logic          done;

    typedef struct {
        string        name;
        logic [W-1:0] cnt;
        logic         tc;
        logic         ovf;
        logic         done;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    counter_bounded #(
        .WIDTH   (W),
        .STEP_W  (SW),
        .RST_VAL ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .updown    (updown),
        .step      (step),
        .min_count (min_count),
        .max_count (max_count),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .clr_ovf   (clr_ovf),
        .cnt       (cnt),
        .tc        (tc),
        .ovf       (ovf),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] c,
                              input logic t, input logic o, input logic d);
        exp_t e;
        e.name = name;
        e.cnt  = c;
        e.tc   = t;
        e.ovf  = o;
        e.done = d;
        sb.push_back(e);
    endtask

    task automatic compare_now();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty: observed 0 entries required 1");
        end else begin
            e = sb.pop_front();
            chk({e.name, ".cnt"},  cnt,            e.cnt);
            chk({e.name, ".tc"},   {{(W-1){1'b0}}, tc},   {{(W-1){1'b0}}, e.tc});
            chk({e.name, ".ovf"},  {{(W-1){1'b0}}, ovf},  {{(W-1){1'b0}}, e.ovf});
            chk({e.name, ".done"}, {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, e.done});
        end
    endtask

    // Sample one time unit after the rising edge, away from the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        compare_now();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; updown = 1'b1; step = '0;
        min_count = '0; max_count = '0; mode = 2'b00;
        load = 1'b0; load_val = '0; clr_ovf = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", '0, 0, 0, 0); compare_now();
        rst = 1'b0;

        // 1: async reset in the middle of counting
        mode = 2'b00; min_count = 0; max_count = 100; step = 1; updown = 1'b1;
        load = 1'b1; load_val = 17;
        expect_out("t1_load", 17, 0, 0, 0); cyc();
        load = 1'b0; ena = 1'b1;
        expect_out("t1_count", 18, 0, 0, 0); cyc();
        #2 rst = 1'b1;
        #1;
        expect_out("t1_async_rst", '0, 0, 0, 0); compare_now();
        expect_out("t1_rst_held", '0, 0, 0, 0); cyc();
        rst = 1'b0; ena = 1'b0;

        // 2: wrap up, step 3, [2,10] from 8
        step = 3; min_count = 2; max_count = 10;
        load = 1'b1; load_val = 8;
        expect_out("t2_load", 8, 0, 0, 0); cyc();
        load = 1'b0; ena = 1'b1;
        expect_out("t2_wrap", 2, 1, 1, 0); cyc();
        expect_out("t2_s5",   5, 0, 1, 0); cyc();
        expect_out("t2_s8",   8, 0, 1, 0); cyc();

        // 3: landing exactly on max is not an event
        step = 2;
        expect_out("t3_exact", 10, 0, 1, 0); cyc();
        expect_out("t3_wrap",   2, 1, 1, 0); cyc();

        // 4: saturate down, step 4, [3,20] from 9
        ena = 1'b0; clr_ovf = 1'b1;
        expect_out("t4_clr", 2, 0, 0, 0); cyc();
        clr_ovf = 1'b0;
        mode = 2'b01; updown = 1'b0; step = 4; min_count = 3; max_count = 20;
        load = 1'b1; load_val = 9; ena = 1'b1;
        expect_out("t4_load", 9, 0, 0, 0); cyc();
        load = 1'b0;
        expect_out("t4_s5",   5, 0, 0, 0); cyc();
        expect_out("t4_sat",  3, 1, 0, 0); cyc();
        expect_out("t4_sat2", 3, 1, 0, 0); cyc();

        // 5: one-shot up, step 1, [0,5] from 4
        mode = 2'b10; updown = 1'b1; step = 1; min_count = 0; max_count = 5;
        load = 1'b1; load_val = 4;
        expect_out("t5_load", 4, 0, 0, 0); cyc();
        load = 1'b0;
        expect_out("t5_exact", 5, 0, 0, 0); cyc();
        expect_out("t5_done",  5, 1, 0, 1); cyc();
        expect_out("t5_frozen", 5, 0, 0, 1); cyc();
        mode = 2'b00;
        expect_out("t5_mode_chg", 5, 0, 0, 1); cyc();
        load = 1'b1; load_val = 0;
        expect_out("t5_reload", 0, 0, 0, 0); cyc();
        load = 1'b0;
        expect_out("t5_resume1", 1, 0, 0, 0); cyc();
        expect_out("t5_resume2", 2, 0, 0, 0); cyc();

        // 6: set beats clear, then clear alone
        step = 3; min_count = 2; max_count = 10;
        load = 1'b1; load_val = 9; clr_ovf = 1'b1;
        expect_out("t6_load", 9, 0, 0, 0); cyc();
        load = 1'b0;
        expect_out("t6_set_wins", 2, 1, 1, 0); cyc();
        ena = 1'b0;
        expect_out("t6_clr", 2, 0, 0, 0); cyc();
        clr_ovf = 1'b0;

        // step 0 holds even outside the bounds; reserved mode wraps
        ena = 1'b1; step = 0; load = 1'b1; load_val = 50;
        expect_out("oob_load", 50, 0, 0, 0); cyc();
        load = 1'b0;
        expect_out("oob_step0", 50, 0, 0, 0); cyc();
        step = 1; mode = 2'b11;
        expect_out("oob_rsvd_wrap", 2, 1, 1, 0); cyc();

        // full-width up wrap: a truncated sum would miss the event
        mode = 2'b00; min_count = 5; max_count = MAXW; step = 200;
        load = 1'b1; load_val = MAXW - 9;
        expect_out("wide_load", MAXW - 9, 0, 1, 0); cyc();
        load = 1'b0;
        expect_out("wide_up_wrap", 5, 1, 1, 0); cyc();
        ena = 1'b0; clr_ovf = 1'b1;
        expect_out("wide_clr", 5, 0, 0, 0); cyc();
        clr_ovf = 1'b0;

        // down step through zero wraps to max
        updown = 1'b0; min_count = 0; step = 10;
        load = 1'b1; load_val = 3;
        expect_out("neg_load", 3, 0, 0, 0); cyc();
        load = 1'b0; ena = 1'b1;
        expect_out("neg_wrap", MAXW, 1, 1, 0); cyc();
        expect_out("neg_after", MAXW - 10, 0, 1, 0); cyc();

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL scoreboard_drain: observed %0d entries required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
